// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 16x16 shift-add multiplier.
package mul_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned PW     = 2 * DW;
    localparam int unsigned N_ITER = 16;
    localparam int unsigned CW     = $clog2(N_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul16_seq_if.sv
// Start/done handshake bundle between an operand source and mul16_seq.
//   start : request pulse, operands a/b sampled on accept
//   a, b  : unsigned 16-bit operands
//   busy  : high while iterating
//   done  : one-cycle pulse, p valid from this cycle
//   p     : 32-bit product register
interface mul16_seq_if;

    logic                        start;
    logic [mul_pkg::DW-1:0]      a;
    logic [mul_pkg::DW-1:0]      b;
    logic                        busy;
    logic                        done;
    logic [mul_pkg::PW-1:0]      p;

    modport master (output start, a, b, input  busy, done, p);
    modport slave  (input  start, a, b, output busy, done, p);

endinterface

// File: rtl/add16.sv
// 16-bit ripple adder built from four add4 slices.
//   x, y : addends   ci : carry in
//   sum  : 16-bit sum co : carry out of the top slice
module add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        ci,
    output logic [15:0] sum,
    output logic        co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_slice
        add4 u_add4 (
            .x   (x[4*i +: 4]),
            .y   (y[4*i +: 4]),
            .ci  (c[i]),
            .sum (sum[4*i +: 4]),
            .co  (c[i+1])
        );
    end

    assign co = c[4];

endmodule

// File: rtl/add4.sv
// 4-bit adder slice with carry in/out; chained by add16.
//   x, y : addends   ci : carry in
//   sum  : 4-bit sum co : carry out
module add4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);

    assign {co, sum} = 5'(x) + 5'(y) + 5'(ci);

endmodule

// File: rtl/mul16_seq.sv
// Sequential unsigned 16x16->32 shift-add multiplier, one partial product
// per clock using a single add16.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mul16_seq_if (start/a/b in, busy/done/p out)
module mul16_seq
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    mul16_seq_if.slave  bus
);

    state_e          state_q, state_d;
    logic [DW-1:0]   m_q, m_d;
    logic [DW-1:0]   q_q, q_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   p_q, p_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [DW-1:0]   add_y;
    logic [DW-1:0]   add_sum;
    logic            add_co;
    logic [PW-1:0]   shifted;

    // Partial product is the multiplicand only when the current multiplier bit is set.
    assign add_y = q_q[0] ? m_q : '0;

    add16 u_add (
        .x   (acc_q),
        .y   (add_y),
        .ci  (1'b0),
        .sum (add_sum),
        .co  (add_co)
    );

    // Carry-out lands in the accumulator MSB; the LSB of q is retired.
    assign shifted = {add_co, add_sum, q_q[DW-1:1]};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        count_d = count_q;
        p_d     = p_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    m_d     = bus.a;
                    q_d     = bus.b;
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                {acc_d, q_d} = shifted;
                count_d      = CW'(count_q + CW'(1));
                if (count_q == CW'(N_ITER - 1)) begin
                    p_d     = shifted;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed vectors with literal results
// plus a cycle-level behavioural model compared on every falling edge.
module tb_mul16_seq;

    logic clk = 1'b0;
    logic rst_n;

    mul16_seq_if bus ();

    mul16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int dut_dones = 0;

    // Behavioural model: a request taken while not iterating yields a*b,
    // reported 16 edges after acceptance as a single done pulse.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_p    = '0;
    logic [31:0] m_pend = '0;
    int          m_rem  = 0;
    int          m_done_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_p    <= '0;
            m_rem  <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy     <= 1'b0;
                m_done     <= 1'b1;
                m_p        <= m_pend;
                m_done_cnt <= m_done_cnt + 1;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_pend <= 32'(bus.a) * 32'(bus.b);
                m_rem  <= 16;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("p", bus.p, m_p);
        if (bus.busy === 1'b1 && bus.done === 1'b1) begin
            chk("busy_and_done", 32'd1, 32'd0);
        end
        if (bus.done === 1'b1) dut_dones++;
    end

    // Present operands for one accept edge, then scramble them.
    task automatic go(input logic [15:0] x, input logic [15:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
    endtask

    // Wait (bounded) for done; lat counts edges from accept, 0 = don't check.
    task automatic wait_done(input logic [31:0] exp, input int lat, input string nm);
        int n = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.done !== 1'b1) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_p"}, bus.p, exp);
            chk({nm, "_model"}, m_p, exp);
            if (lat > 0) chk({nm, "_latency"}, 32'(n), 32'(lat));
        end
    endtask

    initial begin
        int d0;
        logic [15:0] x, y;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_p", bus.p, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic product and latency.
        go(16'd3, 16'd5);
        chk("3x5_busy", 32'(bus.busy), 32'd1);
        wait_done(32'h0000_000F, 17, "3x5");
        @(posedge clk);
        #1;

        // Full-scale operands exercise the adder carry every iteration.
        go(16'hFFFF, 16'hFFFF);
        wait_done(32'hFFFE_0001, 17, "ffff_sq");
        @(posedge clk);
        #1;

        go(16'h8000, 16'h0002);
        wait_done(32'h0001_0000, 17, "8000x2");
        @(posedge clk);
        #1;

        // Previous product must hold until the next completion.
        go(16'h0000, 16'h1234);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_p", bus.p, 32'h0001_0000);
        wait_done(32'h0000_0000, 0, "0x1234");
        @(posedge clk);
        #1;

        // Start during iteration is ignored; exactly one done results.
        d0 = dut_dones;
        go(16'd2, 16'd9);
        repeat (4) @(posedge clk);
        #1;
        go(16'd7, 16'd7);
        wait_done(32'h0000_0012, 0, "2x9");
        // Accept in the DONE cycle for back-to-back operation.
        go(16'd10, 16'd10);
        chk("2x9_one_done", 32'(dut_dones - d0), 32'd1);
        wait_done(32'h0000_0064, 17, "10x10_b2b");
        @(posedge clk);
        #1;

        // Asynchronous abort partway through.
        d0 = dut_dones;
        go(16'd100, 16'd200);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_p", bus.p, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(dut_dones - d0), 32'd0);
        go(16'd100, 16'd200);
        wait_done(32'h0000_4E20, 17, "100x200");
        @(posedge clk);
        #1;

        // Random operands against plain multiplication.
        d0 = dut_dones;
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            go(x, y);
            wait_done(32'(x) * 32'(y), 17, "rand");
            if (($urandom & 1) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        chk("rand_done_count", 32'(dut_dones - d0), 32'd1000);
        chk("total_done_count", 32'(dut_dones), 32'(m_done_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
